psum_ofifo: RTL and testbench

Output collection buffer that sits directly downstream of the array of MAC columns. Each column delivers one signed partial sum per cycle, qualified by its own write strobe. Because the instruction pipeline staggers the columns, these strobes arrive one cycle apart. This block keeps one FIFO lane per column, realigns the skewed results into complete rows, and presents a row to the consumer (SFP/memory write-back) only once every column has contributed.

---
 rtl/psum_ofifo.sv | 107 ++++++++++
 tb/tb_psum_ofifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/psum_ofifo.sv
// psum_ofifo: output collection buffer behind the MAC column array.
// One FIFO lane per column realigns the staggered column results into
// complete rows. A row is presented to the consumer only after every lane
// holds at least one entry. All lanes pop together, so they share a
// single read pointer.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in         per-lane partial sums; lane c is in[(c+1)*bw_psum-1 : c*bw_psum]
//   wr         per-lane write strobes
//   rd         pop one complete row (ignored while o_valid is low)
//   out        show-ahead head entry of every lane, packed like in
//   o_valid    every lane holds at least one entry
//   o_full     at least one lane holds depth entries
//   o_ready    no lane is full
//   o_overflow sticky flag: a write was dropped because its lane was full
module psum_ofifo #(
    parameter int col     = 8,
    parameter int bw_psum = 22,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*bw_psum-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_cnt = depth[aw:0];

    logic [bw_psum-1:0] mem [col][depth];
    logic [aw-1:0]      wr_ptr [col];
    logic [aw:0]        cnt [col];
    logic [aw-1:0]      rd_ptr;

    logic [col-1:0] lane_full;
    logic [col-1:0] lane_nempty;
    logic [col-1:0] accept;
    logic [col-1:0] drop;
    logic           pop;

    always_comb begin
        lane_full   = '0;
        lane_nempty = '0;
        for (int unsigned c = 0; c < col; c++) begin
            lane_full[c]   = (cnt[c] == full_cnt);
            lane_nempty[c] = (cnt[c] != '0);
        end
    end

    assign o_valid = &lane_nempty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    // A pop in the same cycle frees one slot in every lane, so a full lane
    // may still accept its write.
    assign accept  = wr & (~lane_full | {col{pop}});
    assign drop    = wr & lane_full & ~{col{pop}};

    always_comb begin
        out = '0;
        for (int unsigned c = 0; c < col; c++) begin
            out[c*bw_psum +: bw_psum] = mem[c][rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < col; c++) begin
                for (int unsigned d = 0; d < depth; d++) begin
                    mem[c][d] <= '0;
                end
                wr_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            for (int unsigned c = 0; c < col; c++) begin
                if (accept[c]) begin
                    mem[c][wr_ptr[c]] <= in[c*bw_psum +: bw_psum];
                    wr_ptr[c]         <= wr_ptr[c] + 1'b1;
                end
                case ({accept[c], pop})
                    2'b10:   cnt[c] <= cnt[c] + 1'b1;
                    2'b01:   cnt[c] <= cnt[c] - 1'b1;
                    default: cnt[c] <= cnt[c];
                endcase
            end
            if (|drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo: stimulus pushes expected rows into a
// queue, a negedge monitor pops and compares whenever a row is consumed.
module tb_psum_ofifo;

    localparam int COL = 8;
    localparam int BW  = 22;
    localparam int DEP = 16;
    localparam int W   = COL * BW;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in;
    logic [COL-1:0] wr;
    logic         rd;
    logic [W-1:0] out;
    logic         o_valid, o_full, o_ready, o_overflow;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q [$];

    psum_ofifo #(.col(COL), .bw_psum(BW), .depth(DEP)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
        .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] mk_row(input int base, input int stride);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(base + stride * c);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops until o_valid falls; the number of rows popped is compared.
    task automatic drain(input string nm, input int exp_n);
        int n;
        n  = 0;
        rd = 1'b1;
        while (o_valid && n < 64) begin
            tick();
            n++;
        end
        rd = 1'b0;
        check(nm, n, exp_n);
    endtask

    task automatic write_row(input logic [W-1:0] row, input bit expect_kept);
        in = row;
        wr = '1;
        if (expect_kept) exp_q.push_back(row);
        tick();
        wr = '0;
    endtask

    // Monitor: a row is consumed at the next edge whenever rd & o_valid.
    always @(negedge clk) begin
        if (reset && rd && o_valid) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                check("pop_row", out, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b0;
        in = '0; wr = '0; rd = 1'b0;

        // Reset held with random activity
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            wr = COL'($urandom);
            rd = 1'($urandom);
            #1;
            check("rst_out", out, 0);
            check("rst_flags", {o_valid, o_full, o_ready, o_overflow}, 4'b0010);
        end
        in = '0; wr = '0; rd = 1'b0;
        reset = 1'b1;
        tick();
        check("rel_out", out, 0);
        check("rel_flags", {o_valid, o_full, o_ready, o_overflow}, 4'b0010);

        // Skewed fill: lane c writes row r at step r+c
        for (int t = 0; t < 11; t++) begin
            wr = '0;
            in = '0;
            for (int c = 0; c < COL; c++) begin
                if (t - c >= 0 && t - c <= 3) begin
                    wr[c] = 1'b1;
                    in[c*BW +: BW] = BW'(100 * (t - c) + c);
                end
            end
            if (t <= 3) exp_q.push_back(mk_row(100 * t, 1));
            tick();
            check("skew_valid", o_valid, (t >= 7));
            if (t == 7) check("skew_head", out, mk_row(0, 1));
        end
        wr = '0;
        rd = 1'b1;
        repeat (4) tick();
        rd = 1'b0;
        check("skew_empty", o_valid, 0);

        // Full / overflow
        for (int r = 0; r < DEP; r++) write_row(mk_row(32'h200001 + 8 * r, 1), 1'b1);
        check("full_flags", {o_full, o_ready, o_overflow}, 3'b100);
        write_row(mk_row(32'h3FFFFF, 0), 1'b0);
        check("ovf_set", o_overflow, 1);
        check("ovf_head", out, mk_row(32'h200001, 1));
        drain("ovf_drain_cnt", DEP);
        check("ovf_sticky", o_overflow, 1);

        // Clear the sticky flag
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("ovf_cleared", o_overflow, 0);

        // Full with simultaneous rd and wr
        for (int r = 0; r < DEP; r++) write_row(mk_row(32'h200101 + 8 * r, 1), 1'b1);
        rd = 1'b1;
        write_row(mk_row(55, 0), 1'b1);
        rd = 1'b0;
        check("rdwr_flags", {o_full, o_overflow}, 2'b10);
        drain("rdwr_drain_cnt", DEP);

        // Empty read changes nothing
        rd = 1'b1;
        repeat (2) tick();
        rd = 1'b0;
        check("empty_rd_flags", {o_valid, o_full, o_ready, o_overflow}, 4'b0010);
        write_row(mk_row(32'h777, 1), 1'b1);
        check("empty_rd_head", out, mk_row(32'h777, 1));
        drain("empty_rd_drain", 1);

        // Streaming across the pointer wrap
        for (int k = 0; k < 40; k++) begin
            rd = o_valid;
            write_row(mk_row(32'h1000 + 8 * k, 1), 1'b1);
        end
        rd = 1'b0;
        drain("wrap_drain", 1);
        check("wrap_empty", o_valid, 0);

        // Mid-operation asynchronous reset
        for (int r = 0; r < 5; r++) write_row(mk_row(32'h5000 + 8 * r, 1), 1'b1);
        check("pre_rst_valid", o_valid, 1);
        #1 reset = 1'b0;
        #1;
        check("async_valid", o_valid, 0);
        check("async_out", out, 0);
        exp_q.delete();
        #1 reset = 1'b1;
        write_row(mk_row(7000, 1), 1'b1);
        check("fresh_head", out, mk_row(7000, 1));
        drain("fresh_drain", 1);

        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
